// File: rtl/parity_frame_ctrl.sv
// rtl/parity_frame_ctrl.sv - framed byte parity streamer with optional LRC check word
// Optional feature macro: PARITY_LRC_EN (defined: append LRC check word per frame)
module parity_frame_ctrl #(
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_odd,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [8:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_is_lrc,
    output logic       frame_done,
    output logic       trunc
);

`ifdef PARITY_LRC_EN
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_LRC} state_t;
`else
    typedef enum logic [0:0] {S_IDLE, S_DATA} state_t;
`endif

    localparam logic [CNT_W-1:0] LEN_LIM = CNT_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             odd_q;
    logic             out_last;

    logic             slot_free;
    logic             in_fire;
    logic [CNT_W-1:0] cnt_inc;
    logic             hit_len;
    logic             frame_end;
    logic             odd_now;
    logic [8:0]       data_word;

`ifdef PARITY_LRC_EN
    logic [7:0]       acc;
    logic             is_lrc_q;
    assign out_is_lrc = is_lrc_q;
`else
    assign out_is_lrc = 1'b0;
`endif

    // The output register can take a new word when empty or being drained this cycle
    assign slot_free  = !out_valid || out_ready;
    assign in_ready   = slot_free && ((state == S_IDLE) || (state == S_DATA));
    assign in_fire    = in_valid && in_ready;

    // Byte number of the incoming byte within the frame decides forced end
    assign cnt_inc    = cnt + 1'b1;
    assign hit_len    = (state == S_IDLE) ? (MAX_LEN == 1) : (cnt_inc == LEN_LIM);
    assign frame_end  = in_last || hit_len;

    // First byte of a frame uses cfg_odd directly; later bytes use the latched flag
    assign odd_now    = (state == S_IDLE) ? cfg_odd : odd_q;
    assign data_word  = {(^in_data) ^ odd_now, in_data};

    // The frame's final word is marked so its acceptance can be reported
    assign frame_done = out_valid && out_ready && out_last;

    // Frame sequencer and output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            odd_q     <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            trunc     <= 1'b0;
`ifdef PARITY_LRC_EN
            acc       <= '0;
            is_lrc_q  <= 1'b0;
`endif
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (in_fire) begin
                out_data  <= data_word;
                out_valid <= 1'b1;
                if (state == S_IDLE) begin
                    odd_q <= cfg_odd;
                    cnt   <= CNT_ONE;
                end else begin
                    cnt   <= cnt_inc;
                end
                // Cleared on a frame's first byte, set only by a forced end
                trunc <= hit_len && !in_last;
`ifdef PARITY_LRC_EN
                acc      <= (state == S_IDLE) ? in_data : (acc ^ in_data);
                is_lrc_q <= 1'b0;
                out_last <= 1'b0;
                state    <= frame_end ? S_LRC : S_DATA;
`else
                out_last <= frame_end;
                state    <= frame_end ? S_IDLE : S_DATA;
`endif
            end
`ifdef PARITY_LRC_EN
            else if ((state == S_LRC) && slot_free) begin
                out_data  <= {(^acc) ^ odd_q, acc};
                out_valid <= 1'b1;
                is_lrc_q  <= 1'b1;
                out_last  <= 1'b1;
                state     <= S_IDLE;
            end
`endif
        end
    end

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// tb/tb_parity_frame_ctrl.sv - randomized and directed checks of parity_frame_ctrl against a frame-level model
module tb_parity_frame_ctrl;

    localparam int MAX_LEN = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_odd = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic [8:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       out_is_lrc;
    logic       frame_done;
    logic       trunc;

    int checks = 0;
    int errors = 0;
    logic rand_ready = 1'b0;

    parity_frame_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .cfg_odd(cfg_odd), .in_data(in_data),
        .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_is_lrc(out_is_lrc), .frame_done(frame_done), .trunc(trunc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic par(input logic [7:0] b, input logic o);
        return ((($countones(b) + int'(o)) % 2) == 1);
    endfunction

    function automatic logic [10:0] e(input logic d, input logic l, input logic [8:0] w);
        return {d, l, w};
    endfunction

    // Frame-level reference model
    logic [7:0] fq[$];
    logic       m_valid = 1'b0, m_lrc = 1'b0, m_last = 1'b0, m_pending = 1'b0;
    logic       m_odd = 1'b0, m_trunc = 1'b0;
    logic [8:0] m_word = 9'h0;
    logic [7:0] m_lrc_byte = 8'h0;
    logic       sf, inf, exp_ready;
    logic [7:0] x;

    always @(negedge clk) begin
        if (rst) begin
            fq.delete();
            m_valid = 0; m_lrc = 0; m_last = 0; m_pending = 0;
            m_odd = 0; m_trunc = 0; m_word = 0; m_lrc_byte = 0;
            chk("rst_out_data", 32'(out_data), 32'h0);
        end
        exp_ready = (!m_valid || out_ready) && !m_pending;
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            chk("out_data", 32'(out_data), 32'(m_word));
            chk("out_is_lrc", 32'(out_is_lrc), 32'(m_lrc));
        end
        chk("frame_done", 32'(frame_done), 32'(m_valid && out_ready && m_last));
        chk("trunc", 32'(trunc), 32'(m_trunc));
        if (!rst) begin
            sf  = !m_valid || out_ready;
            inf = in_valid && sf && !m_pending;
            if (m_valid && out_ready) m_valid = 0;
            if (inf) begin
                if (fq.size() == 0) begin
                    m_odd   = cfg_odd;
                    m_trunc = 0;
                end
                fq.push_back(in_data);
                m_word  = {par(in_data, m_odd), in_data};
                m_valid = 1; m_lrc = 0; m_last = 0;
                if (in_last || fq.size() == MAX_LEN) begin
                    m_trunc = !in_last;
`ifdef PARITY_LRC_EN
                    x = 8'h00;
                    foreach (fq[i]) x = x ^ fq[i];
                    m_lrc_byte = x;
                    m_pending  = 1;
`else
                    m_last = 1;
`endif
                    fq.delete();
                end
            end else if (m_pending && sf) begin
                m_word = {par(m_lrc_byte, m_odd), m_lrc_byte};
                m_valid = 1; m_lrc = 1; m_last = 1; m_pending = 0;
            end
        end
    end

    // Log of accepted output words: {frame_done, out_is_lrc, out_data}
    logic [10:0] log_q[$];
    logic [10:0] exp_q[$];

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) log_q.push_back({frame_done, out_is_lrc, out_data});
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input logic l, input logic o);
        int n = 0;
        in_valid = 1; in_data = b; in_last = l; cfg_odd = o;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) chk("send_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        in_valid = 0; in_last = 0;
    endtask

    task automatic idle(input int n);
        in_valid = 0;
        in_last  = 1'($urandom);
        in_data  = 8'($urandom);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        in_last = 0;
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        while (out_valid && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) chk("drain_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_log(input string name);
        chk({name, "_len"}, 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            chk(name, 32'(log_q[i]), 32'(exp_q[i]));
        log_q.delete();
        exp_q.delete();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data", 32'(out_data), 32'd0);
        chk("reset_out_is_lrc", 32'(out_is_lrc), 32'd0);
        chk("reset_frame_done", 32'(frame_done), 32'd0);
        chk("reset_trunc", 32'(trunc), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        rst = 0;
        @(posedge clk);
        #1;

        // Even frame 01 03 FF
        log_q.delete();
        send_byte(8'h01, 0, 0);
        send_byte(8'h03, 0, 0);
        send_byte(8'hFF, 1, 0);
        drain();
        exp_q.push_back(e(0, 0, 9'h101));
        exp_q.push_back(e(0, 0, 9'h003));
`ifdef PARITY_LRC_EN
        exp_q.push_back(e(0, 0, 9'h0FF));
        exp_q.push_back(e(1, 1, 9'h1FD));
`else
        exp_q.push_back(e(1, 0, 9'h0FF));
`endif
        check_log("even_frame");

        // Odd single zero byte, then even single zero byte
        send_byte(8'h00, 1, 1);
        drain();
        send_byte(8'h00, 1, 0);
        drain();
`ifdef PARITY_LRC_EN
        exp_q.push_back(e(0, 0, 9'h100));
        exp_q.push_back(e(1, 1, 9'h100));
        exp_q.push_back(e(0, 0, 9'h000));
        exp_q.push_back(e(1, 1, 9'h000));
`else
        exp_q.push_back(e(1, 0, 9'h100));
        exp_q.push_back(e(1, 0, 9'h000));
`endif
        check_log("single_byte");

        // Backpressure: hold out_ready low with a word pending
        out_ready = 0;
        send_byte(8'h5A, 0, 0);
        in_valid = 1; in_data = 8'h3C; in_last = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_out_data", 32'(out_data), 32'h05A);
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1;
        send_byte(8'h3C, 1, 0);
        drain();
        exp_q.push_back(e(0, 0, 9'h05A));
`ifdef PARITY_LRC_EN
        exp_q.push_back(e(0, 0, 9'h03C));
        exp_q.push_back(e(1, 1, 9'h066));
`else
        exp_q.push_back(e(1, 0, 9'h03C));
`endif
        check_log("backpressure");

        // Truncation at MAX_LEN, odd parity
        send_byte(8'h11, 0, 1);
        send_byte(8'h22, 0, 1);
        send_byte(8'h44, 0, 1);
        send_byte(8'h88, 0, 1);
        chk("trunc_set", 32'(trunc), 32'd1);
        drain();
        chk("trunc_sticky", 32'(trunc), 32'd1);
        send_byte(8'h0F, 1, 1);
        chk("trunc_clear", 32'(trunc), 32'd0);
        drain();
        exp_q.push_back(e(0, 0, 9'h111));
        exp_q.push_back(e(0, 0, 9'h122));
        exp_q.push_back(e(0, 0, 9'h144));
`ifdef PARITY_LRC_EN
        exp_q.push_back(e(0, 0, 9'h188));
        exp_q.push_back(e(1, 1, 9'h1FF));
        exp_q.push_back(e(0, 0, 9'h10F));
        exp_q.push_back(e(1, 1, 9'h10F));
`else
        exp_q.push_back(e(1, 0, 9'h188));
        exp_q.push_back(e(1, 0, 9'h10F));
`endif
        check_log("truncation");

        // Reset during byte 2 of a frame
        send_byte(8'hA5, 0, 0);
        in_valid = 1; in_data = 8'h5A;
        rst = 1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_data", 32'(out_data), 32'd0);
        chk("midrst_out_is_lrc", 32'(out_is_lrc), 32'd0);
        chk("midrst_frame_done", 32'(frame_done), 32'd0);
        chk("midrst_trunc", 32'(trunc), 32'd0);
        in_valid = 0;
        @(posedge clk);
        #1;
        rst = 0;
        log_q.delete();
        send_byte(8'h01, 1, 0);
        drain();
`ifdef PARITY_LRC_EN
        exp_q.push_back(e(0, 0, 9'h101));
        exp_q.push_back(e(1, 1, 9'h101));
`else
        exp_q.push_back(e(1, 0, 9'h101));
`endif
        check_log("after_reset");

        // Randomized stream with random backpressure, gaps, parity and one reset
        rand_ready = 1;
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
            send_byte(8'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom));
            if (i == 120) begin
                rst = 1;
                @(posedge clk);
                #1;
                rst = 0;
            end
        end
        rand_ready = 0;
        @(posedge clk);
        #1;
        out_ready = 1;
        drain();
        repeat (4) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
